// File: rtl/arb4_rr_ctrl_if.sv
// Request/grant bundle between the requesting units and the round-robin arbiter.
// The requester side uses the master modport and the arbiter uses the slave modport.
interface arb4_rr_ctrl_if;
  logic [3:0] REQ;
  logic [3:0] GNT;
  logic [1:0] GNT_IDX;
  logic       BUSY;
  logic       TIMEOUT;

  modport master (
    output REQ,
    input  GNT,
    input  GNT_IDX,
    input  BUSY,
    input  TIMEOUT
  );

  modport slave (
    input  REQ,
    output GNT,
    output GNT_IDX,
    output BUSY,
    output TIMEOUT
  );
endinterface

// File: rtl/arb4_rr_ctrl.sv
// Four-way round-robin arbiter with a registered one-hot grant and an optional hold limit.
// Every grant is followed by at least one idle cycle before the next grant is issued.
module arb4_rr_ctrl #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  arb4_rr_ctrl_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  // Counter value seen on the edge where the hold limit fires; unused when MAX_HOLD is 0.
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  state_t           state, state_nxt;
  logic [1:0]       ptr, ptr_nxt;
  logic [1:0]       idx, idx_nxt;
  logic [CNT_W-1:0] hcnt, hcnt_nxt;
  logic             timeout, timeout_nxt;
  logic [3:0]       gnt, gnt_nxt;
  logic [1:0]       pick;
  logic             pick_vld;
  logic             hold_hit;

  function automatic logic [3:0] decode2(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

  // Descending scan so the requester closest to the pointer is assigned last and wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (bus.REQ[ptr + 2'(k)]) begin
        pick     = ptr + 2'(k);
        pick_vld = 1'b1;
      end
    end
  end

  assign hold_hit = (MAX_HOLD != 0) && (hcnt == HOLD_LAST);

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    idx_nxt     = idx;
    hcnt_nxt    = hcnt;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          idx_nxt   = pick;
          hcnt_nxt  = '0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        // A dropped request takes precedence, so a coincident hold limit raises no TIMEOUT.
        if (!bus.REQ[idx]) begin
          state_nxt = IDLE;
          ptr_nxt   = idx + 2'd1;
        end else if (hold_hit) begin
          state_nxt   = IDLE;
          ptr_nxt     = idx + 2'd1;
          timeout_nxt = 1'b1;
        end else begin
          hcnt_nxt = hcnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    gnt_nxt = (state_nxt == GRANT) ? decode2(idx_nxt) : 4'b0000;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      ptr     <= '0;
      idx     <= '0;
      hcnt    <= '0;
      timeout <= 1'b0;
      gnt     <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      idx     <= idx_nxt;
      hcnt    <= hcnt_nxt;
      timeout <= timeout_nxt;
      gnt     <= gnt_nxt;
    end
  end

  assign bus.GNT     = gnt;
  assign bus.GNT_IDX = idx;
  assign bus.BUSY    = (state == GRANT);
  assign bus.TIMEOUT = timeout;

endmodule

// File: tb/tb_arb4_rr_ctrl.sv
// Directed bench for arb4_rr_ctrl: four instances cover hold limits 8, 2, 4 and unlimited.
module tb_arb4_rr_ctrl;

  logic CLK;
  logic RST_N;
  int   total;
  int   bad;

  arb4_rr_ctrl_if if8 ();
  arb4_rr_ctrl_if if2 ();
  arb4_rr_ctrl_if if4 ();
  arb4_rr_ctrl_if if0 ();

  arb4_rr_ctrl #(.MAX_HOLD(8), .CNT_W(4)) u_dut8 (.CLK(CLK), .RST_N(RST_N), .bus(if8));
  arb4_rr_ctrl #(.MAX_HOLD(2), .CNT_W(4)) u_dut2 (.CLK(CLK), .RST_N(RST_N), .bus(if2));
  arb4_rr_ctrl #(.MAX_HOLD(4), .CNT_W(4)) u_dut4 (.CLK(CLK), .RST_N(RST_N), .bus(if4));
  arb4_rr_ctrl #(.MAX_HOLD(0), .CNT_W(4)) u_dut0 (.CLK(CLK), .RST_N(RST_N), .bus(if0));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b expected=%b", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it before sampling.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    if8.REQ = 4'b0000;
    if2.REQ = 4'b0000;
    if4.REQ = 4'b0000;
    if0.REQ = 4'b0000;
    RST_N = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  logic [3:0] rot_gnt [13];
  logic       to_seen;

  initial begin
    total = 0;
    bad   = 0;
    RST_N = 1'b1;
    if8.REQ = 4'b0000;
    if2.REQ = 4'b0000;
    if4.REQ = 4'b0000;
    if0.REQ = 4'b0000;
    rot_gnt = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
    #2;

    // Some activity first so the reset below lands mid-simulation.
    do_reset();
    if8.REQ = 4'b0001;
    step();
    step();

    // Reset, then idle for five cycles.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      chk("rst_gnt",     {4'b0, if8.GNT},       8'h00);
      chk("rst_idx",     {6'b0, if8.GNT_IDX},   8'h00);
      chk("rst_busy",    {7'b0, if8.BUSY},      8'h00);
      chk("rst_timeout", {7'b0, if8.TIMEOUT},   8'h00);
      step();
    end

    // Single requester with normal release, then the pointer points past it.
    do_reset();
    if8.REQ = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("single_gnt",  {4'b0, if8.GNT},     8'b0100);
      chk("single_idx",  {6'b0, if8.GNT_IDX}, 8'd2);
      chk("single_busy", {7'b0, if8.BUSY},    8'd1);
    end
    if8.REQ = 4'b0000;
    step();
    chk("single_rel_gnt", {4'b0, if8.GNT},     8'b0000);
    chk("single_rel_to",  {7'b0, if8.TIMEOUT}, 8'd0);
    chk("single_rel_idx", {6'b0, if8.GNT_IDX}, 8'd2);
    if8.REQ = 4'b1111;
    step();
    chk("single_next_gnt", {4'b0, if8.GNT}, 8'b1000);

    // Rotation with forced release every two cycles.
    do_reset();
    if2.REQ = 4'b1111;
    for (int c = 0; c < 13; c++) begin
      step();
      chk("rot_gnt", {4'b0, if2.GNT}, {4'b0, rot_gnt[c]});
      chk("rot_timeout", {7'b0, if2.TIMEOUT}, (rot_gnt[c] == 4'b0000) ? 8'd1 : 8'd0);
    end

    // Wrap from requester 3 to requester 0 with a dead cycle in between.
    do_reset();
    if8.REQ = 4'b0100;
    step();
    if8.REQ = 4'b0000;
    step();
    if8.REQ = 4'b1001;
    step();
    chk("wrap_gnt3", {4'b0, if8.GNT}, 8'b1000);
    if8.REQ = 4'b0001;
    step();
    chk("wrap_dead", {4'b0, if8.GNT}, 8'b0000);
    step();
    chk("wrap_gnt0", {4'b0, if8.GNT},     8'b0001);
    chk("wrap_idx0", {6'b0, if8.GNT_IDX}, 8'd0);

    // Request drop coincident with the hold limit counts as a normal release.
    do_reset();
    if4.REQ = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("simul_gnt", {4'b0, if4.GNT}, 8'b0010);
    end
    if4.REQ = 4'b0000;
    step();
    chk("simul_rel_gnt", {4'b0, if4.GNT},     8'b0000);
    chk("simul_rel_to",  {7'b0, if4.TIMEOUT}, 8'd0);

    // Unlimited hold, then asynchronous reset between edges.
    do_reset();
    if0.REQ = 4'b0001;
    to_seen = 1'b0;
    step();
    for (int c = 0; c < 20; c++) begin
      chk("unl_gnt", {4'b0, if0.GNT}, 8'b0001);
      to_seen = to_seen | if0.TIMEOUT;
      step();
    end
    chk("unl_no_timeout", {7'b0, to_seen}, 8'd0);
    #2;
    RST_N = 1'b0;
    #1;
    chk("async_gnt",  {4'b0, if0.GNT},     8'b0000);
    chk("async_busy", {7'b0, if0.BUSY},    8'd0);
    chk("async_to",   {7'b0, if0.TIMEOUT}, 8'd0);
    #1;
    RST_N = 1'b1;
    if0.REQ = 4'b0110;
    step();
    chk("post_rst_gnt", {4'b0, if0.GNT},     8'b0010);
    chk("post_rst_idx", {6'b0, if0.GNT_IDX}, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
